// File: rtl/div_iter.sv
// div_iter: iterative restoring divider, one quotient bit per clock.
// A start captures the operands, WIDTH RUN cycles follow, then a single
// DONE cycle presents the quotient on oData and the remainder on oRem.
// Build option: define DIV_SIGNED_EN to enable signed division via iSigned;
// without it iSigned is ignored and no sign logic is built.
module div_iter #(
    parameter int WIDTH = 32
) (
    input  logic             iClk,
    input  logic             iRst,
    input  logic             iStart,
    input  logic             iSigned,
    input  logic [WIDTH-1:0] iDataA,
    input  logic [WIDTH-1:0] iDataB,
    output logic [WIDTH-1:0] oData,
    output logic [WIDTH-1:0] oRem,
    output logic             oBusy,
    output logic             oDone
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [5:0]     LAST_ITER = 6'(WIDTH - 1);
    localparam logic [WIDTH:0] ONE_W1    = (WIDTH + 1)'(1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] r_q, r_d;        // partial remainder
    logic [WIDTH-1:0] quo_q, quo_d;    // dividend shifts out, quotient shifts in
    logic [WIDTH-1:0] div_q, div_d;    // divisor magnitude
    logic [5:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [WIDTH-1:0] rem_q, rem_d;

    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;
    logic             diff_neg;
    logic [WIDTH-1:0] r_iter;
    logic [WIDTH-1:0] quo_iter;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    logic [WIDTH-1:0] fin_quo;
    logic [WIDTH-1:0] fin_rem;

`ifdef DIV_SIGNED_EN
    logic neg_quo_q, neg_quo_d;        // negate quotient at completion
    logic neg_rem_q, neg_rem_d;        // negate remainder at completion
    logic sign_a;
    logic sign_b;
`else
    logic unused_signed;
    assign unused_signed = iSigned;
`endif

    // Trial subtraction through the add path: {R, Q msb} + ~D + 1. A set
    // bit WIDTH means the shifted remainder was smaller than the divisor.
    assign shifted  = {r_q, quo_q[WIDTH-1]};
    assign diff     = shifted + {1'b1, ~div_q} + ONE_W1;
    assign diff_neg = diff[WIDTH];
    assign r_iter   = diff_neg ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
    assign quo_iter = {quo_q[WIDTH-2:0], ~diff_neg};

    // Operand magnitudes and result sign correction.
`ifdef DIV_SIGNED_EN
    assign sign_a  = iSigned & iDataA[WIDTH-1];
    assign sign_b  = iSigned & iDataB[WIDTH-1];
    assign mag_a   = sign_a ? -iDataA : iDataA;
    assign mag_b   = sign_b ? -iDataB : iDataB;
    assign fin_quo = neg_quo_q ? -quo_iter : quo_iter;
    assign fin_rem = neg_rem_q ? -r_iter : r_iter;
`else
    assign mag_a   = iDataA;
    assign mag_b   = iDataB;
    assign fin_quo = quo_iter;
    assign fin_rem = r_iter;
`endif

    // Next-state and datapath update for capture, iteration and completion.
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can leave it unassigned and infer a latch.
        state_d = state_q;
        r_d     = r_q;
        quo_d   = quo_q;
        div_d   = div_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        rem_d   = rem_q;
`ifdef DIV_SIGNED_EN
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
`endif
        case (state_q)
            S_IDLE, S_DONE: begin
                if (iStart) begin
                    state_d = S_RUN;
                    r_d     = '0;
                    quo_d   = mag_a;
                    div_d   = mag_b;
                    cnt_d   = '0;
`ifdef DIV_SIGNED_EN
                    // A zero divisor must still give -1, so never negate it.
                    neg_quo_d = (sign_a ^ sign_b) & (|iDataB);
                    neg_rem_d = sign_a;
`endif
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                r_d   = r_iter;
                quo_d = quo_iter;
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == LAST_ITER) begin
                    state_d = S_DONE;
                    data_d  = fin_quo;
                    rem_d   = fin_rem;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge iClk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (iRst) begin
            state_q <= S_IDLE;
            r_q     <= '0;
            quo_q   <= '0;
            div_q   <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            rem_q   <= '0;
`ifdef DIV_SIGNED_EN
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            quo_q   <= quo_d;
            div_q   <= div_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            rem_q   <= rem_d;
`ifdef DIV_SIGNED_EN
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
`endif
        end
    end

    assign oData = data_q;
    assign oRem  = rem_q;
    assign oBusy = (state_q == S_RUN);
    assign oDone = (state_q == S_DONE);

endmodule

// File: tb/tb_div_iter.sv
// tb_div_iter: table vectors, hand-written multi-cycle sequences and random
// operations against an arithmetic reference model of the divider.
// Signed vectors are exercised when DIV_SIGNED_EN is defined.
module tb_div_iter;

    localparam int W = 32;

    logic         iClk = 1'b0;
    logic         iRst;
    logic         iStart;
    logic         iSigned;
    logic [W-1:0] iDataA;
    logic [W-1:0] iDataB;
    logic [W-1:0] oData;
    logic [W-1:0] oRem;
    logic         oBusy;
    logic         oDone;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         sgn;
        logic [W-1:0] q;
        logic [W-1:0] r;
    } vec_t;

    vec_t vecs[$];

    div_iter #(.WIDTH(W)) dut (
        .iClk    (iClk),
        .iRst    (iRst),
        .iStart  (iStart),
        .iSigned (iSigned),
        .iDataA  (iDataA),
        .iDataB  (iDataB),
        .oData   (oData),
        .oRem    (oRem),
        .oBusy   (oBusy),
        .oDone   (oDone)
    );

    always #5 iClk = ~iClk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic with the defined zero/overflow cases.
    function automatic void ref_div(input logic [W-1:0] a, input logic [W-1:0] b,
                                    input logic s, output logic [W-1:0] q,
                                    output logic [W-1:0] r);
`ifdef DIV_SIGNED_EN
        if (s) begin
            if (b == 0) begin
                q = '1;
                r = a;
            end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                q = 32'h8000_0000;
                r = '0;
            end else begin
                q = 32'($signed(a) / $signed(b));
                r = 32'($signed(a) % $signed(b));
            end
            return;
        end
`endif
        if (b == 0) begin
            q = '1;
            r = a;
        end else begin
            q = a / b;
            r = a % b;
        end
    endfunction

    // Issue a start at the next edge and wait (bounded) for oDone.
    // lat counts edges after the start edge; busy_ok drops if oBusy fell early.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                         output int lat, output bit busy_ok);
        iDataA  = a;
        iDataB  = b;
        iSigned = s;
        iStart  = 1'b1;
        @(posedge iClk); #1;
        iStart  = 1'b0;
        iDataA  = $urandom;
        iDataB  = $urandom;
        iSigned = 1'($urandom);
        lat     = 0;
        busy_ok = 1'b1;
        while (!oDone && lat < 100) begin
            if (!oBusy) busy_ok = 1'b0;
            @(posedge iClk); #1;
            lat++;
        end
    endtask

    task automatic check_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic s, input logic [W-1:0] eq, input logic [W-1:0] er);
        int lat;
        bit busy_ok;
        do_op(a, b, s, lat, busy_ok);
        check({name, "_latency"}, 64'(lat), 64'(W));
        check({name, "_busy"}, 64'(busy_ok), 64'(1));
        check({name, "_busy_low"}, 64'(oBusy), 64'(0));
        check({name, "_quo"}, 64'(oData), 64'(eq));
        check({name, "_rem"}, 64'(oRem), 64'(er));
    endtask

    initial begin
        int lat;
        bit flag;
        logic [W-1:0] a, b, eq, er;
        logic s;

        #2000000;
        $display("FAIL global_timeout: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int  lat;
        bit  flag;
        logic [W-1:0] a, b, eq, er;
        logic s;

        vecs.push_back('{32'd100,         32'd7,          1'b0, 32'd14,          32'd2});
        vecs.push_back('{32'h1234_5678,   32'd0,          1'b0, 32'hFFFF_FFFF,   32'h1234_5678});
        vecs.push_back('{32'hFFFF_FFFF,   32'd1,          1'b0, 32'hFFFF_FFFF,   32'd0});
        vecs.push_back('{32'd0,           32'd5,          1'b0, 32'd0,           32'd0});
        vecs.push_back('{32'd5,           32'hFFFF_FFFF,  1'b0, 32'd0,           32'd5});
        vecs.push_back('{32'hFFFF_FFFF,   32'hFFFF_FFFF,  1'b0, 32'd1,           32'd0});
        vecs.push_back('{32'h8000_0000,   32'd2,          1'b0, 32'h4000_0000,   32'd0});
`ifdef DIV_SIGNED_EN
        vecs.push_back('{32'hFFFF_FFF9,   32'd2,          1'b1, 32'hFFFF_FFFD,   32'hFFFF_FFFF});
        vecs.push_back('{32'h8000_0000,   32'hFFFF_FFFF,  1'b1, 32'h8000_0000,   32'd0});
        vecs.push_back('{32'hFFFF_FFFB,   32'd0,          1'b1, 32'hFFFF_FFFF,   32'hFFFF_FFFB});
        vecs.push_back('{32'd7,           32'hFFFF_FFFE,  1'b1, 32'hFFFF_FFFD,   32'd1});
        vecs.push_back('{32'hFFFF_FFF8,   32'hFFFF_FFFD,  1'b1, 32'd2,           32'hFFFF_FFFE});
`else
        vecs.push_back('{32'hFFFF_FFF9,   32'd2,          1'b1, 32'h7FFF_FFFC,   32'd1});
`endif

        iRst    = 1'b1;
        iStart  = 1'b1;
        iSigned = 1'b0;
        iDataA  = 32'd9;
        iDataB  = 32'd3;
        repeat (3) @(posedge iClk);
        #1;
        check("reset_data", 64'(oData), 64'(0));
        check("reset_rem",  64'(oRem),  64'(0));
        check("reset_busy", 64'(oBusy), 64'(0));
        check("reset_done", 64'(oDone), 64'(0));
        iRst   = 1'b0;
        iStart = 1'b0;

        // Table vectors, each followed by a check that oDone is a single pulse.
        foreach (vecs[i]) begin
            check_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].sgn,
                     vecs[i].q, vecs[i].r);
            @(posedge iClk); #1;
            check($sformatf("vec%0d_done_pulse", i), 64'(oDone), 64'(0));
            check($sformatf("vec%0d_hold", i), 64'(oData), 64'(vecs[i].q));
        end

        // Back-to-back start during oDone, with a stray start mid-run.
        check_op("b2b_first", 32'd100, 32'd7, 1'b0, 32'd14, 32'd2);
        iDataA = 32'hFFFF_FFFF;
        iDataB = 32'd1;
        iSigned = 1'b0;
        iStart = 1'b1;
        @(posedge iClk); #1;
        iStart = 1'b0;
        check("b2b_busy_rise", 64'(oBusy), 64'(1));
        check("b2b_done_low",  64'(oDone), 64'(0));
        check("b2b_hold_quo",  64'(oData), 64'(14));
        check("b2b_hold_rem",  64'(oRem),  64'(2));
        lat = 0;
        repeat (4) begin
            @(posedge iClk); #1;
            lat++;
        end
        iDataA = 32'd3;
        iDataB = 32'd3;
        iStart = 1'b1;
        @(posedge iClk); #1;
        lat++;
        iStart = 1'b0;
        while (!oDone && lat < 100) begin
            @(posedge iClk); #1;
            lat++;
        end
        check("b2b_latency", 64'(lat), 64'(W));
        check("b2b_quo", 64'(oData), 64'hFFFF_FFFF);
        check("b2b_rem", 64'(oRem),  64'(0));

        // Reset at cycle 10 of 50/5: everything clears, no oDone follows.
        iDataA = 32'd50;
        iDataB = 32'd5;
        iStart = 1'b1;
        @(posedge iClk); #1;
        iStart = 1'b0;
        repeat (9) @(posedge iClk);
        #1;
        iRst = 1'b1;
        @(posedge iClk); #1;
        iRst = 1'b0;
        check("rst_mid_data", 64'(oData), 64'(0));
        check("rst_mid_rem",  64'(oRem),  64'(0));
        check("rst_mid_busy", 64'(oBusy), 64'(0));
        check("rst_mid_done", 64'(oDone), 64'(0));
        flag = 1'b0;
        repeat (40) begin
            @(posedge iClk); #1;
            if (oDone || oBusy) flag = 1'b1;
        end
        check("rst_no_done", 64'(flag), 64'(0));
        check_op("rst_restart", 32'd50, 32'd5, 1'b0, 32'd10, 32'd0);

        // Random operations; some start straight from DONE, some from IDLE.
        for (int n = 0; n < 150; n++) begin
            a = $urandom;
            case ($urandom_range(0, 4))
                0: b = $urandom;
                1: b = $urandom >> $urandom_range(1, 31);
                2: b = 32'($urandom_range(0, 15));
                3: b = a >> $urandom_range(0, 8);
                default: b = 32'($urandom_range(1, 3)) << $urandom_range(0, 31);
            endcase
            if ($urandom_range(0, 9) == 0) a = 32'h8000_0000;
            if ($urandom_range(0, 9) == 0) b = 32'hFFFF_FFFF;
            s = 1'($urandom);
            ref_div(a, b, s, eq, er);
            check_op($sformatf("rnd%0d", n), a, b, s, eq, er);
            if ($urandom_range(0, 1) == 1) begin
                @(posedge iClk); #1;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
